uart_frame_arbiter: RTL and testbench

//  Shares the single UART transmitter between NUM_SRC byte-stream requesters (board serializers, status/message senders).

---
 rtl/uart_frame_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_frame_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin share of one UART TX, frames SOF, ID, payload and a checksum byte when FRAME_CHECKSUM_EN is defined
module uart_frame_arbiter #(
  parameter int NUM_SRC = 4,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int MAX_LEN = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_SRC-1:0] req_valid,
  input  logic [8*NUM_SRC-1:0] req_data,
  input  logic [NUM_SRC-1:0] req_last,
  output logic [NUM_SRC-1:0] req_ready,
  output logic [7:0] uart_tx_data,
  output logic uart_tx_valid,
  input  logic uart_tx_ready,
  output logic [2:0] grant_id,
  output logic busy,
  output logic overrun
);
  localparam int CW = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {
    IDLE,
    SOF,
    ID,
    PAYLOAD,
`ifdef FRAME_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;
  state_t state, nxt;
  logic [2:0] rr, win, idx;
  logic [3:0] s;
  logic [CW-1:0] cnt;
  logic [7:0] vld, lst, rdy, pbyte;
  logic [63:0] dat;
  logic ld, acc, xfer, fin;
  assign vld = 8'(req_valid);
  assign lst = 8'(req_last);
  assign dat = 64'(req_data);
  assign pbyte = dat[{grant_id, 3'b000} +: 8];
  assign ld = !uart_tx_valid || uart_tx_ready;
  assign acc = uart_tx_valid && uart_tx_ready;
  assign xfer = state == PAYLOAD && vld[grant_id] && ld;
  assign fin = lst[grant_id] || cnt == CW'(MAX_LEN - 1);
  // scan offsets from far to near so the closest requester at or after rr wins
  always_comb begin
    win = '0;
    s = '0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      s = {1'b0, rr} + 4'(k);
      idx = s >= 4'(NUM_SRC) ? 3'(s - 4'(NUM_SRC)) : s[2:0];
      if (vld[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = |req_valid ? SOF : IDLE;
      SOF: nxt = acc ? ID : SOF;
      ID: nxt = acc ? PAYLOAD : ID;
`ifdef FRAME_CHECKSUM_EN
      PAYLOAD: nxt = xfer && fin ? CKSUM : PAYLOAD;
      CKSUM: nxt = ld ? DONE : CKSUM;
`else
      PAYLOAD: nxt = xfer && fin ? DONE : PAYLOAD;
`endif
      DONE: nxt = acc ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    rdy = '0;
    rdy[grant_id] = state == PAYLOAD && ld;
    busy = state != IDLE;
    overrun = xfer && !lst[grant_id] && cnt == CW'(MAX_LEN - 1);
  end
  assign req_ready = rdy[NUM_SRC-1:0];
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] ck;
  always_ff @(posedge clk or posedge rst)
    if (rst) ck <= '0;
    else if (state == SOF && acc) ck <= {5'b0, grant_id};
    else if (xfer) ck <= ck ^ pbyte;
`endif
  // single output register, reloaded in its drain cycle for back-to-back bytes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uart_tx_data <= '0;
      uart_tx_valid <= 1'b0;
      grant_id <= '0;
      rr <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        grant_id <= win;
        cnt <= '0;
        uart_tx_data <= SOF_BYTE;
        uart_tx_valid <= 1'b1;
      end else if (state == SOF && acc) begin
        uart_tx_data <= {5'b0, grant_id};
        uart_tx_valid <= 1'b1;
      end else if (xfer) begin
        uart_tx_data <= pbyte;
        uart_tx_valid <= 1'b1;
        cnt <= cnt + CW'(1);
`ifdef FRAME_CHECKSUM_EN
      end else if (state == CKSUM && ld) begin
        uart_tx_data <= ck;
        uart_tx_valid <= 1'b1;
`endif
      end else if (acc) begin
        uart_tx_valid <= 1'b0;
      end
      if (state == DONE && acc) rr <= grant_id == 3'(NUM_SRC - 1) ? 3'd0 : grant_id + 3'd1;
    end
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter: directed frame streams with a byte-level UART monitor; expectations follow FRAME_CHECKSUM_EN
module tb_uart_frame_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_last = '0;
  logic [3:0] req_ready;
  logic [31:0] req_data = '0;
  logic [7:0] uart_tx_data;
  logic uart_tx_valid;
  logic uart_tx_ready = 1'b1;
  logic [2:0] grant_id;
  logic busy, overrun;
  logic tog = 1'b0;
  logic [3:0] fire = '0;
  logic [8:0] sq [4][$];
  logic [7:0] got [$];
  logic [7:0] exp [$];
  int n_chk = 0;
  int n_pass = 0;
  int n_ovr = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd = '0;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_frame_arbiter #(.NUM_SRC(4), .SOF_BYTE(8'hA5), .MAX_LEN(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .grant_id(grant_id),
    .busy(busy),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, req);
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      h = 9'h000;
      if (sq[i].size() > 0) h = sq[i][0];
      req_valid[i] = sq[i].size() > 0;
      req_data[8*i +: 8] = h[7:0];
      req_last[i] = h[8];
    end
  endtask

  task automatic push(input int src, input logic [7:0] b, input logic l);
    sq[src].push_back({l, b});
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) sq[i].delete();
    drive();
  endtask

  function automatic bit pend();
    pend = 1'b0;
    for (int i = 0; i < 4; i++) if (sq[i].size() > 0) pend = 1'b1;
  endfunction

  task automatic e(input logic [7:0] b);
    exp.push_back(b);
  endtask

  task automatic ce(input logic [7:0] b);
    if (CK) exp.push_back(b);
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((pend() || busy || uart_tx_valid) && c < 300);
    chk({tag, "_timeout"}, 32'(c >= 300), 0);
  endtask

  task automatic cmp(input string tag);
    logic [31:0] g;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = 32'hdead;
      if (i < got.size()) g = 32'(got[i]);
      chk($sformatf("%s_byte%0d", tag, i), g, 32'(exp[i]));
    end
    got.delete();
    exp.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(uart_tx_valid), 0);
    chk("rst_data", 32'(uart_tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    got.delete();
    exp.delete();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    if (tog) uart_tx_ready = !uart_tx_ready;
    drive();
  end

  always @(negedge clk) begin
    fire = req_valid & req_ready;
    if (rst) pv = 1'b0;
    else begin
      if (pv && !pr) chk("hold", {23'b0, uart_tx_valid, uart_tx_data}, {23'b0, 1'b1, pd});
      if (uart_tx_valid && uart_tx_ready) got.push_back(uart_tx_data);
      if (overrun) n_ovr++;
      if (req_ready != 0) chk("rdy_gnt", 32'(req_ready), 32'(1) << grant_id);
      pv = uart_tx_valid;
      pr = uart_tx_ready;
      pd = uart_tx_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    do_reset();
    push(1, 8'h12, 1'b0);
    push(1, 8'h34, 1'b1);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_gnt", 32'(grant_id), 1);
    chk("t1_valid", 32'(uart_tx_valid), 1);
    chk("t1_sof", 32'(uart_tx_data), 32'hA5);
    chk("t1_rdy", 32'(req_ready), 0);
    wait_done("t1");
    e(8'hA5); e(8'h01); e(8'h12); e(8'h34); ce(8'h27);
    cmp("t1");
    push(2, 8'h5A, 1'b1);
    push(1, 8'h66, 1'b1);
    wait_done("rr");
    e(8'hA5); e(8'h02); e(8'h5A); ce(8'h58);
    e(8'hA5); e(8'h01); e(8'h66); ce(8'h67);
    cmp("rr");
    tog = 1'b1;
    push(1, 8'h12, 1'b0);
    push(1, 8'h34, 1'b1);
    wait_done("t3");
    tog = 1'b0;
    uart_tx_ready = 1'b1;
    e(8'hA5); e(8'h01); e(8'h12); e(8'h34); ce(8'h27);
    cmp("t3");
    n_ovr = 0;
    for (int i = 1; i <= 6; i++) push(0, 8'(i), 1'(i == 6));
    wait_done("t4");
    e(8'hA5); e(8'h00); e(8'h01); e(8'h02); e(8'h03); e(8'h04); ce(8'h04);
    e(8'hA5); e(8'h00); e(8'h05); e(8'h06); ce(8'h03);
    cmp("t4");
    chk("t4_overrun", 32'(n_ovr), 1);
    do_reset();
    push(0, 8'h10, 1'b1);
    push(2, 8'h20, 1'b1);
    push(3, 8'h30, 1'b1);
    wait_done("t2a");
    push(0, 8'h40, 1'b1);
    push(3, 8'h50, 1'b1);
    wait_done("t2b");
    e(8'hA5); e(8'h00); e(8'h10); ce(8'h10);
    e(8'hA5); e(8'h02); e(8'h20); ce(8'h22);
    e(8'hA5); e(8'h03); e(8'h30); ce(8'h33);
    e(8'hA5); e(8'h00); e(8'h40); ce(8'h40);
    e(8'hA5); e(8'h03); e(8'h50); ce(8'h53);
    cmp("t2");
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b0);
    push(0, 8'h44, 1'b1);
    c = 0;
    while (got.size() < 4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t5_wait_timeout", 32'(c >= 100), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    flush();
    #1;
    chk("t5_valid", 32'(uart_tx_valid), 0);
    chk("t5_data", 32'(uart_tx_data), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_gnt", 32'(grant_id), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_ovr", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    exp.delete();
    push(0, 8'h77, 1'b1);
    wait_done("t5");
    e(8'hA5); e(8'h00); e(8'h77); ce(8'h77);
    cmp("t5");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
